// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   RAM_ADDR_W / RAM_DATA_W : geometry of the 128x8 single-port data RAM
//   DEFAULT_MAX_WAIT        : host wait cycles before the core is forced to stall
//   arb_state_t             : host read tracking FSM states
//   sat_inc16()             : 16-bit saturating increment used by the statistics counters
package ram_arb_pkg;

  localparam int RAM_ADDR_W       = 7;
  localparam int RAM_DATA_W       = 8;
  localparam int DEFAULT_MAX_WAIT = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the core, host and RAM-macro signals around the RAM port arbiter.
// Latency: n/a (wiring only).
// Backpressure: host holds its request fields until it samples host_gnt; core obeys cpu_stall.
//
// Signal groups:
//   core : cpu_sel, cpu_we, cpu_addr, cpu_wdata -> arbiter; cpu_rdata, cpu_stall <- arbiter
//   host : host_req, host_we, host_addr, host_wdata -> arbiter;
//          host_gnt, host_rvalid, host_rdata <- arbiter
//   ram  : ram_addr, ram_we, ram_din <- arbiter; ram_dout -> arbiter
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding core / host / RAM view
interface ram_arb_if #(
  parameter int ADDR_W = ram_arb_pkg::RAM_ADDR_W,
  parameter int DATA_W = ram_arb_pkg::RAM_DATA_W
);

  logic              cpu_sel;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  cpu_sel, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output ram_addr, ram_we, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_sel, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  ram_addr, ram_we, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/ram_port_arbiter_wait_ctr.sv
// Starvation counter: counts cycles a host request has waited without a grant.
// Latency: force_ok_o is registered-state based, valid in the cycle after the count reaches MAX_WAIT.
// Backpressure: none; it only observes host_req/host_gnt.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset (count cleared)
//   host_req_i  : host request pending this cycle
//   host_gnt_i  : host granted this cycle (clears the count)
//   force_ok_o  : the host has waited MAX_WAIT cycles; the core may be stalled for it
module ram_arb_wait_ctr
  import ram_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic host_req_i,
  input  logic host_gnt_i,
  output logic force_ok_o
);

  // Wide enough to hold MAX_WAIT itself; a zero MAX_WAIT still gets one bit.
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (host_gnt_i || !host_req_i) begin
      cnt_d = '0;
    end else if (cnt_q < MAX_CNT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // MAX_WAIT of zero means the core is never forced to give way.
  assign force_ok_o = (MAX_WAIT != 0) && (cnt_q >= MAX_CNT);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the CPU core (priority) and a host requester.
// Latency: host write/grant same cycle as request when free; host read data valid gnt + 2 cycles.
// Backpressure: host waits for host_gnt; core is stalled for one cycle when the host has starved.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   bus (ram_arb_if)     : core request/stall, host request/grant/read-return, RAM macro pins
//   stat_host_grants     : (RAM_ARB_STATS_EN only) saturating count of host grants
//   stat_cpu_stalls      : (RAM_ARB_STATS_EN only) saturating count of forced core stalls
// Build option: define RAM_ARB_STATS_EN to add the two statistics outputs; without it
// the ports and counters are absent and behaviour is otherwise identical.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic        clk,
  input  logic        reset,
`ifdef RAM_ARB_STATS_EN
  output logic [15:0] stat_host_grants,
  output logic [15:0] stat_cpu_stalls,
`endif
  ram_arb_if.slave    bus
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              host_rvalid_q;
  logic              host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q;
  logic [DATA_W-1:0] host_rdata_d;

  logic              force_ok;
  logic              force_stall;
  logic              in_rd_wait;
  logic              host_gnt_c;
  logic              cpu_stall_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_we_c;
  logic [DATA_W-1:0] ram_din_c;

  ram_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk        (clk),
    .reset      (reset),
    .host_req_i (bus.host_req),
    .host_gnt_i (host_gnt_c),
    .force_ok_o (force_ok)
  );

  assign in_rd_wait = (state_q == RD_WAIT);

  // A forced stall is pointless while a read is outstanding, since the host
  // could not be granted anyway; keep it off so the core is not held for nothing.
  assign force_stall = bus.host_req && force_ok && !in_rd_wait && !reset;

  // Per-cycle ownership of the RAM port. Host is never granted during reset.
  always_comb begin
    ram_addr_c  = bus.cpu_addr;
    ram_we_c    = 1'b0;
    ram_din_c   = bus.cpu_wdata;
    host_gnt_c  = 1'b0;
    cpu_stall_c = 1'b0;
    if (bus.cpu_sel && !force_stall) begin
      ram_we_c = bus.cpu_we;
    end else if (bus.host_req && !in_rd_wait && !reset) begin
      ram_addr_c  = bus.host_addr;
      ram_we_c    = bus.host_we;
      ram_din_c   = bus.host_wdata;
      host_gnt_c  = 1'b1;
      // Only reachable with cpu_sel high when the stall was forced.
      cpu_stall_c = bus.cpu_sel;
    end
  end

  // Read tracking: the RAM returns data one cycle after the address, so the
  // capture happens at the end of the single RD_WAIT cycle. Core traffic in
  // RD_WAIT only changes what ram_dout shows in the following cycle.
  always_comb begin
    state_d       = state_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    case (state_q)
      IDLE: begin
        if (host_gnt_c && !bus.host_we) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_d       = IDLE;
        host_rvalid_d = 1'b1;
        host_rdata_d  = bus.ram_dout;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_we      = ram_we_c;
  assign bus.ram_din     = ram_din_c;
  assign bus.host_gnt    = host_gnt_c;
  assign bus.cpu_stall   = cpu_stall_c;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  // Core read data comes straight from the macro; no extra pipeline stage.
  assign bus.cpu_rdata   = bus.ram_dout;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] stat_gnt_q;
  logic [15:0] stat_gnt_d;
  logic [15:0] stat_stall_q;
  logic [15:0] stat_stall_d;

  always_comb begin
    stat_gnt_d   = stat_gnt_q;
    stat_stall_d = stat_stall_q;
    if (host_gnt_c) begin
      stat_gnt_d = sat_inc16(stat_gnt_q);
    end
    if (cpu_stall_c) begin
      stat_stall_d = sat_inc16(stat_stall_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_gnt_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_gnt_q   <= stat_gnt_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_host_grants = stat_gnt_q;
  assign stat_cpu_stalls  = stat_stall_q;
`endif

endmodule
